// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator core: operator codes,
// controller states and the key-event priority picker.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {IDLE, PEND, DIV, ERR} state_t;

    // Bit positions in the key vector; a higher position wins a tie.
    localparam int K_ENTER = 4;
    localparam int K_ADD   = 3;
    localparam int K_SUB   = 2;
    localparam int K_MUL   = 1;
    localparam int K_DIV   = 0;

    typedef struct packed {
        logic       vld;
        logic       enter;
        logic [1:0] op;
    } key_evt_t;

    function automatic key_evt_t pick_event(input logic [4:0] ev);
        key_evt_t e;
        e = '0;
        if (ev[K_ENTER]) begin
            e.vld   = 1'b1;
            e.enter = 1'b1;
        end else if (ev[K_ADD]) begin
            e.vld = 1'b1;
            e.op  = OP_ADD;
        end else if (ev[K_SUB]) begin
            e.vld = 1'b1;
            e.op  = OP_SUB;
        end else if (ev[K_MUL]) begin
            e.vld = 1'b1;
            e.op  = OP_MUL;
        end else if (ev[K_DIV]) begin
            e.vld = 1'b1;
            e.op  = OP_DIV;
        end
        return e;
    endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per clock, RW iterations after
// start. done and quotient are presented combinationally on the last iteration.
module calc_divider #(
    parameter int W  = 8,
    parameter int RW = 2*W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] dividend,
    input  logic [W-1:0]  divisor,
    output logic          done,
    output logic [RW-1:0] quotient
);

    localparam int CNT_W = $clog2(RW);

    logic [W-1:0]     rem_q, dsr_q, rem_n;
    logic [RW-1:0]    quo_q, quo_n;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic [W:0]       shifted;
    logic             fit;

    always_comb begin
        shifted = {rem_q, quo_q[RW-1]};
        fit     = shifted >= {1'b0, dsr_q};
        rem_n   = fit ? W'(shifted - {1'b0, dsr_q}) : shifted[W-1:0];
        quo_n   = {quo_q[RW-2:0], fit};
    end

    assign done     = active_q && (cnt_q == CNT_W'(RW-1));
    assign quotient = quo_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dsr_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= '0;
            dsr_q    <= divisor;
            quo_q    <= dividend;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 1'b1;
            if (done)
                active_q <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_core_seq.sv
// Sequential calculator core: edge-detected keys drive an accumulator with
// operator chaining, saturating add/sub/mul and an iterative divider.
module calc_core_seq
    import calc_pkg::*;
#(
    parameter int W      = 8,
    parameter int RW     = 2*W,
    parameter bit SAT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  num_in,
    input  logic          op_add,
    input  logic          op_sub,
    input  logic          op_mul,
    input  logic          op_div,
    input  logic          op_enter,
    output logic [RW-1:0] result,
    output logic [1:0]    op_display,
    output logic          op_pending,
    output logic          busy,
    output logic          ovf,
    output logic          err
);

    state_t        state_q, state_n;
    logic [4:0]    key_cur, key_prev;
    key_evt_t      evt;
    logic [RW-1:0] result_q, result_n;
    logic [1:0]    op_q, op_n, next_op_q, next_op_n;
    logic          pend_q, pend_n, busy_q, busy_n, ovf_q, ovf_n, err_q, err_n;
    logic          have_q, have_n, chain_q, chain_n;
    logic          div_start, div_done;
    logic [RW-1:0] div_quot;

    logic [RW:0]     sum, diff;
    logic [RW+W-1:0] prod;
    logic [RW-1:0]   alu_res;
    logic            alu_ovf;

    assign evt = pick_event(key_cur & ~key_prev);

    calc_divider #(.W(W), .RW(RW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (result_q),
        .divisor  (num_in),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        sum     = {1'b0, result_q} + {1'b0, RW'(num_in)};
        diff    = {1'b0, result_q} - {1'b0, RW'(num_in)};
        prod    = {{W{1'b0}}, result_q} * {{RW{1'b0}}, num_in};
        alu_res = sum[RW-1:0];
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_ovf = sum[RW];
                alu_res = (SAT_EN && sum[RW]) ? '1 : sum[RW-1:0];
            end
            OP_SUB: begin
                alu_ovf = diff[RW];
                alu_res = (SAT_EN && diff[RW]) ? '0 : diff[RW-1:0];
            end
            OP_MUL: begin
                alu_ovf = |prod[RW+W-1:RW];
                alu_res = (SAT_EN && alu_ovf) ? '1 : prod[RW-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state_q;
        result_n  = result_q;
        op_n      = op_q;
        next_op_n = next_op_q;
        pend_n    = pend_q;
        busy_n    = busy_q;
        ovf_n     = ovf_q;
        err_n     = err_q;
        have_n    = have_q;
        chain_n   = chain_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt.vld && !evt.enter) begin
                    // After enter the accumulator is the left operand.
                    if (!have_q)
                        result_n = RW'(num_in);
                    op_n    = evt.op;
                    pend_n  = 1'b1;
                    ovf_n   = 1'b0;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (evt.vld) begin
                    if (op_q == OP_DIV) begin
                        ovf_n = 1'b0;
                        if (num_in == '0) begin
                            err_n    = 1'b1;
                            result_n = '0;
                            pend_n   = 1'b0;
                            state_n  = ERR;
                        end else begin
                            div_start = 1'b1;
                            busy_n    = 1'b1;
                            chain_n   = !evt.enter;
                            next_op_n = evt.op;
                            state_n   = DIV;
                        end
                    end else begin
                        result_n = alu_res;
                        ovf_n    = alu_ovf;
                        if (evt.enter) begin
                            pend_n  = 1'b0;
                            have_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            op_n = evt.op;
                        end
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    result_n = div_quot;
                    busy_n   = 1'b0;
                    if (chain_q) begin
                        op_n    = next_op_q;
                        state_n = PEND;
                    end else begin
                        pend_n  = 1'b0;
                        have_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            key_cur   <= '0;
            key_prev  <= '0;
            result_q  <= '0;
            op_q      <= OP_ADD;
            next_op_q <= OP_ADD;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            have_q    <= 1'b0;
            chain_q   <= 1'b0;
        end else begin
            // History keeps updating in DIV/ERR so held keys never re-fire.
            key_cur   <= {op_enter, op_add, op_sub, op_mul, op_div};
            key_prev  <= key_cur;
            state_q   <= state_n;
            result_q  <= result_n;
            op_q      <= op_n;
            next_op_q <= next_op_n;
            pend_q    <= pend_n;
            busy_q    <= busy_n;
            ovf_q     <= ovf_n;
            err_q     <= err_n;
            have_q    <= have_n;
            chain_q   <= chain_n;
        end
    end

    assign result     = result_q;
    assign op_display = op_q;
    assign op_pending = pend_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_core_seq.sv
// Bench for calc_core_seq: directed scenarios plus randomized key sequences
// checked against an arithmetic reference model of the calculator.
module tb_calc_core_seq;

    localparam int W = 8;
    localparam int RW = 16;
    localparam bit SAT_EN = 1'b1;
    localparam longint MAXV = (64'd1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  num_in = '0;
    logic          op_add = 0, op_sub = 0, op_mul = 0, op_div = 0, op_enter = 0;
    logic [RW-1:0] result;
    logic [1:0]    op_display;
    logic          op_pending, busy, ovf, err;

    int n_cmp = 0;
    int n_fail = 0;

    calc_core_seq #(.W(W), .RW(RW), .SAT_EN(SAT_EN)) dut (
        .clk(clk), .rst(rst), .num_in(num_in),
        .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul), .op_div(op_div),
        .op_enter(op_enter), .result(result), .op_display(op_display),
        .op_pending(op_pending), .busy(busy), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model state. Keys: 0 add, 1 sub, 2 mul, 3 div, 4 enter.
    longint m_res;
    int     m_op;
    bit     m_pend, m_have, m_ovf, m_err;

    function automatic logic [RW+5:0] obs();
        return {result, op_display, op_pending, busy, ovf, err};
    endfunction

    function automatic logic [RW+5:0] expv();
        return {RW'(m_res), 2'(m_op), m_pend, 1'b0, m_ovf, m_err};
    endfunction

    task automatic model_reset();
        m_res = 0; m_op = 0; m_pend = 0; m_have = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_event(input int k, input int n, output bit is_div);
        longint r;
        is_div = 0;
        if (m_err) return;
        if (!m_pend) begin
            if (k == 4) return;
            if (!m_have) m_res = n;
            m_op = k; m_pend = 1; m_ovf = 0;
            return;
        end
        if (m_op == 3) begin
            m_ovf = 0;
            if (n == 0) begin
                m_err = 1; m_res = 0; m_pend = 0;
                return;
            end
            m_res = m_res / n;
            is_div = 1;
        end else begin
            case (m_op)
                0: r = m_res + n;
                1: r = m_res - n;
                default: r = m_res * n;
            endcase
            if (r > MAXV) begin
                m_ovf = 1; r = SAT_EN ? MAXV : (r & MAXV);
            end else if (r < 0) begin
                m_ovf = 1; r = SAT_EN ? 0 : (r & MAXV);
            end else begin
                m_ovf = 0;
            end
            m_res = r;
        end
        if (k == 4) begin
            m_pend = 0; m_have = 1;
        end else begin
            m_op = k;
        end
    endtask

    function automatic logic [4:0] kmask(input int k);
        logic [4:0] m;
        m = (k == 4) ? 5'b10000 : (5'b01000 >> k);
        return m;
    endfunction

    function automatic int top_key(input logic [4:0] m);
        if (m[4]) return 4;
        for (int i = 3; i >= 0; i--) if (m[i]) return 3 - i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_keys(input logic [4:0] m);
        {op_enter, op_add, op_sub, op_mul, op_div} = m;
    endtask

    // Key sampled at the first edge (cycle 0); returns just after cycle 1.
    task automatic press_mask(input logic [4:0] m, input int n);
        num_in = W'(n);
        set_keys(m);
        step();
        set_keys(5'b0);
        step();
    endtask

    task automatic press(input int k, input int n);
        press_mask(kmask(k), n);
    endtask

    task automatic do_reset();
        rst = 1; set_keys(5'b0);
        step(); step();
        rst = 0;
        model_reset();
    endtask

    task automatic wait_div(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            step(); cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        n_cmp++;
        if (obs() !== '0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", obs());
        end
        rst = 0; model_reset();
    endtask

    task automatic test_add();
        bit d;
        do_reset();
        press(0, 25); model_event(0, 25, d);
        press(4, 17); model_event(4, 17, d);
        n_cmp++;
        if (result !== 16'd42 || op_pending !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL add_basic: result=%0d pend=%b ovf=%b want 42/0/0", result, op_pending, ovf);
        end
        n_cmp++;
        if (obs() !== expv()) begin
            n_fail++; $display("FAIL add_model: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_chain();
        bit d;
        do_reset();
        press(2, 12); model_event(2, 12, d);
        press(1, 10); model_event(1, 10, d);
        n_cmp++;
        if (result !== 16'd120 || op_display !== 2'd1 || op_pending !== 1'b1) begin
            n_fail++; $display("FAIL chain_mid: result=%0d op=%0d pend=%b want 120/1/1", result, op_display, op_pending);
        end
        press(4, 20); model_event(4, 20, d);
        n_cmp++;
        if (result !== 16'd100 || op_pending !== 1'b0) begin
            n_fail++; $display("FAIL chain_end: result=%0d pend=%b want 100/0", result, op_pending);
        end
        // Operator after enter reuses the accumulator, not num_in.
        press(0, 77); model_event(0, 77, d);
        press(4, 5); model_event(4, 5, d);
        n_cmp++;
        if (result !== 16'd105 || obs() !== expv()) begin
            n_fail++; $display("FAIL chain_reuse: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_saturate();
        bit d;
        do_reset();
        press(2, 255); model_event(2, 255, d);
        press(2, 255); model_event(2, 255, d);
        n_cmp++;
        if (result !== 16'd65025 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL sat_mid: result=%0d ovf=%b want 65025/0", result, ovf);
        end
        press(4, 255); model_event(4, 255, d);
        n_cmp++;
        if (result !== 16'd65535 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL sat_mul: result=%0d ovf=%b want 65535/1", result, ovf);
        end
        press(0, 1); model_event(0, 1, d);
        press(4, 1); model_event(4, 1, d);
        n_cmp++;
        if (result !== 16'd65535 || ovf !== 1'b1 || obs() !== expv()) begin
            n_fail++; $display("FAIL sat_add: got %h want %h", obs(), expv());
        end
        do_reset();
        press(1, 5); model_event(1, 5, d);
        press(4, 9); model_event(4, 9, d);
        n_cmp++;
        if (result !== 16'd0 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL underflow: result=%0d ovf=%b want 0/1", result, ovf);
        end
    endtask

    task automatic test_divide();
        bit d;
        int cyc;
        do_reset();
        press(3, 200); model_event(3, 200, d);
        press(4, 7); model_event(4, 7, d);
        n_cmp++;
        if (busy !== 1'b1 || result !== 16'd200) begin
            n_fail++; $display("FAIL div_start: busy=%b result=%0d want 1/200", busy, result);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (cyc == 3) op_add = 1;
            if (cyc == 4) op_add = 0;
            step(); cyc++;
        end
        n_cmp++;
        if (cyc != RW || result !== 16'd28 || op_pending !== 1'b0 || obs() !== expv()) begin
            n_fail++; $display("FAIL div_basic: busy_cycles=%0d got %h want %0d cycles %h", cyc, obs(), RW, expv());
        end
        // Held add across the divide must not fire once busy drops.
        press(3, 0); model_event(3, 0, d);
        num_in = 3; set_keys(kmask(4)); step();
        set_keys(5'b0); op_add = 1; step();
        model_event(4, 3, d);
        wait_div(cyc);
        step(); step(); step();
        n_cmp++;
        if (result !== 16'd9 || op_pending !== 1'b0 || obs() !== expv()) begin
            n_fail++; $display("FAIL div_held_key: got %h want %h", obs(), expv());
        end
        op_add = 0; step();
    endtask

    task automatic test_error();
        bit d;
        do_reset();
        press(3, 9); model_event(3, 9, d);
        press(4, 0); model_event(4, 0, d);
        n_cmp++;
        if (err !== 1'b1 || result !== 16'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL div_zero: err=%b result=%0d busy=%b want 1/0/0", err, result, busy);
        end
        press(0, 5); model_event(0, 5, d);
        press(4, 2); model_event(4, 2, d);
        n_cmp++;
        if (err !== 1'b1 || op_pending !== 1'b0 || result !== 16'd0 || obs() !== expv()) begin
            n_fail++; $display("FAIL err_sticky: got %h want %h", obs(), expv());
        end
        rst = 1; step();
        n_cmp++;
        if (obs() !== '0) begin
            n_fail++; $display("FAIL err_clear: got %h want 0", obs());
        end
        rst = 0; model_reset();
    endtask

    task automatic test_rst_mid_div();
        do_reset();
        press(3, 100);
        press(4, 3);
        step(); step(); step();
        rst = 1; step();
        n_cmp++;
        if (obs() !== '0) begin
            n_fail++; $display("FAIL rst_mid_div: got %h want 0", obs());
        end
        rst = 0; model_reset();
        step(); step();
        press(0, 4); press(4, 6);
        n_cmp++;
        if (result !== 16'd10 || busy !== 1'b0) begin
            n_fail++; $display("FAIL after_abort: result=%0d busy=%b want 10/0", result, busy);
        end
    endtask

    task automatic test_priority();
        bit d;
        logic [4:0] masks [4] = '{5'b11000, 5'b01110, 5'b00110, 5'b00011};
        int nums [4] = '{5, 4, 3, 2};
        do_reset();
        press(0, 10); model_event(0, 10, d);
        for (int i = 0; i < 4; i++) begin
            press_mask(masks[i], nums[i]);
            model_event(top_key(masks[i]), nums[i], d);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL priority_%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        bit d;
        int k, n, cyc;
        do_reset();
        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 4);
            n = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
            if (k == 2 && $urandom_range(0, 1) == 1) n = $urandom_range(0, 3);
            press(k, n);
            model_event(k, n, d);
            if (d) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_busy it=%0d: busy=%b want 1", it, busy);
                end
                wait_div(cyc);
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_div_timeout it=%0d: busy=%b want 0", it, busy);
                end
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL rnd_it%0d key=%0d num=%0d: got %h want %h", it, k, n, obs(), expv());
            end
            if (m_err || $urandom_range(0, 40) == 0) do_reset();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_chain();
        test_saturate();
        test_divide();
        test_error();
        test_rst_mid_div();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_core_seq.md
Name: calc_core_seq

Overview:
- Parametrised sequential arithmetic core: next generation of the board calculator datapath.
- Adds configurable operand width, a fourth operation (divide, iterative), operator chaining, and saturation/error flags.
- Sits between the debounce stage and the display driver.
- Inputs are debounced levels; all edge detection is done internally.

Parameters:
- W, 8, operand width of num_in.
- RW, 2*W, accumulator/result width.
- SAT_EN, 1, 1 = saturate on overflow/underflow; 0 = wrap modulo 2^RW (flags still set).

Ports:
- clk  input  1  system clock (debounce-rate clock domain).
- rst  input  1  synchronous, active-high reset.
- num_in  input  W  unsigned operand from switches.
- op_add  input  1  debounced level, add key.
- op_sub  input  1  debounced level, subtract key.
- op_mul  input  1  debounced level, multiply key.
- op_div  input  1  debounced level, divide key.
- op_enter  input  1  debounced level, equals key.
- result  output  RW  accumulator value for display.
- op_display  output  2  pending operator: 0 add, 1 sub, 2 mul, 3 div.
- op_pending  output  1  an operator is latched and awaiting its second operand.
- busy  output  1  divide in progress; keys ignored.
- ovf  output  1  last operation overflowed or underflowed (sticky until next operation).
- err  output  1  divide-by-zero; sticky until rst.

Behaviour:
- Reset values: result=0, op_display=0, op_pending=0, busy=0, ovf=0, err=0, state IDLE, key history regs=0.
- Edge detect: each key is registered; an event is cur&~prev. One event is processed per cycle.
- Priority for simultaneous events: enter > add > sub > mul > div.
- Timing: cycle 0 is the clk edge at which a key is first sampled high. The event fires in cycle 0.
  - add/sub/mul: result updates at cycle 1.
  - div: busy=1 from cycle 1; result and busy=0 at cycle RW+1.
- States:
  - IDLE: operator event -> result<=zero-extended num_in, latch op, op_pending=1, go PEND. enter -> no change.
  - PEND, operator event (chaining): compute result op num_in, then latch the new op and stay in PEND. If the pending op is div, go DIV and latch the new op on completion.
  - PEND, enter: compute, then op_pending=0, go IDLE. The result stays as the new left operand for a following operator.
    - In IDLE after enter, an operator event reuses result rather than num_in.
    - A fresh number only enters after rst (clear).
  - DIV: all key events are dropped, but history regs still update so held keys do not re-fire. On completion -> PEND if chained, IDLE if entered.
  - ERR: entered when div is selected with num_in==0. Sets err=1, result=0, busy stays 0. All keys are ignored until rst.
- Arithmetic (unsigned):
  - add: RW+1-bit sum; the carry sets ovf. SAT_EN gives 2^RW-1.
  - sub: a borrow sets ovf. SAT_EN gives 0.
  - mul: full RW+W product; any nonzero bit above RW-1 sets ovf. SAT_EN gives 2^RW-1.
  - div: quotient only, truncated; ovf=0.
- ovf clears at the start of each new computation.
- rst mid-divide: aborts immediately and all outputs return to reset values next cycle.

Decomposition:
- Package calc_pkg:
  - op encoding constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - state enum IDLE/PEND/DIV/ERR.
  - key-priority ordering.
- Sub-module calc_divider: restoring, one quotient bit per cycle, RW cycles.
  - Interface: start pulse, dividend RW, divisor W, done pulse, quotient RW.
  - Parametrised on RW/W.
- Edge detect and the add/sub/mul datapath stay inline in calc_core_seq.

Test Plan (W=8, RW=16, SAT_EN=1):
- rst; num_in=25, op_add pulse; num_in=17, op_enter -> result=42 at cycle 1 after enter, op_pending=0, ovf=0.
- Chaining 12 mul, 10 sub, 20 enter -> result=120 after sub event, op_display=1, final result=100.
- Saturation 255 mul, 255 mul, 255 enter -> 65025, then product overflows -> result=65535, ovf=1.
- Underflow 5 sub, 9 enter -> result=0, ovf=1.
- Divide 200 div, 7 enter -> busy high 16 cycles, result=28 at cycle 17. A mid-divide op_add pulse is ignored. A held op_add does not fire after busy falls.
- Errors:
  - 9 div, 0 enter -> err=1, result=0, and subsequent keys have no effect.
  - rst clears all outputs.
  - rst asserted during a divide -> all outputs 0 next cycle, busy=0.
